autosym_expander: RTL
=====================

# autosym_expander

Sequential evaluator that rebuilds a full Boolean function from its autosymmetric reduction: f(x) = f_k(A·x). It is the decoding end of the team's autosymmetry reduction flow. The block holds a programmable GF(2) projection matrix A and a cube cover of the reduced function f_k. It accepts input vectors through a valid/ready handshake and returns one output bit per query. It lets reduced benchmark netlists be checked cycle-by-cycle against the original PLA behaviour.

## Interface
- N_IN, 6, width of the original input vector x
- N_RED, 4, number of reduced variables (matrix rows)
- N_CUBES, 8, cube table depth
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = matrix row, 1 = cube entry
- cfg_addr  in  $clog2(max(N_RED,N_CUBES))  row or cube index
- cfg_data  in  CW = max(N_IN, 2*N_RED+1)  row: bits [N_IN-1:0]; cube: [2*N_RED]=enable, [2*N_RED-1:N_RED]=care mask, [N_RED-1:0]=value
- cfg_busy  out  1  high whenever state != IDLE
- in_valid / in_ready  in/out  1  query handshake
- in_x  in  N_IN  query vector
- out_valid / out_ready  out/in  1  result handshake
- out_y  out  1  f(x)

## Operation
- States: IDLE, PROJ, SCAN, DONE.
- IDLE: in_ready=1. On in_valid, latch in_x and go to PROJ.
- PROJ: compute z[j] = XOR-reduce(row[j] & x_reg) for j < N_RED. Register z, clear idx, go to SCAN.
- SCAN: evaluate cube[idx]. Match = enable & ((z ^ value) & care) == 0.
  - Match: y=1, go to DONE.
  - No match at idx == N_CUBES-1: y=0, go to DONE.
  - Otherwise: idx++.
- DONE: out_valid=1, out_y held stable. On out_ready, go to IDLE. No overlap between queries.
- Config writes take effect only in IDLE. Writes in any other state are dropped silently. Out-of-range cfg_addr is ignored.
- A cfg write and a query accepted on the same IDLE edge: the write lands first, so the query uses the new contents.
- Reset clears all rows to 0 and all cubes to 0 (disabled). An empty table yields y=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_y=0, cfg_busy=0, idx=0.
- Edge E0 is the acceptance edge. E1 completes PROJ. Edge E(2+i) evaluates cube i.
- Hit at cube i: out_valid high after edge E(2+i), giving latency i+3 edges.
- Miss: latency N_CUBES+2 edges.
- Minimum query period is latency + 1 (the DONE→IDLE edge), assuming out_ready is held high.
- rst_n low in any state: the next edge forces reset values and drops any in-flight query.

## Configuration
- AUTOSYM_EARLY_EXIT_EN defined: SCAN stops at the first matching cube (latency i+3 on a hit).
- Undefined: SCAN always walks all N_CUBES entries and ORs the matches. Latency is fixed at N_CUBES+2 regardless of data, giving constant-time evaluation for equivalence benches.
- out_y is identical in both builds.

## Structure
- autosym_pkg: state enum; cfg_sel encodings; localparams for CW, cube field offsets (ENABLE_BIT, CARE_LSB, VALUE_LSB) and index width.
- Sub-module autosym_project: combinational N_RED×N_IN GF(2) matrix-vector product (per-row AND + parity). It is instantiated once and registered in PROJ.
- Top module autosym_expander holds the register files, FSM, scan counter and handshakes.

## Test plan
- Reset, then query x=6'h3F -> out_y=0 after 10 edges. in_ready=1 before acceptance, 0 during the query.
- Write row0=6'b000001, row1=6'b000110, cube0={en=1, care=4'b0011, val=4'b0001}:
  - Query 6'b000111 -> out_y=1; latency 3 with EARLY_EXIT, 10 without.
  - Query 6'b000011 -> out_y=0, latency 10 in both builds.
- Only cube7 enabled and matching -> out_y=1 at latency 10 in both builds.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_y stable, in_ready=0.
  - A cfg write issued then is dropped; a repeat query gives the same result.
- Assert rst_n=0 during SCAN -> next edge out_valid=0, in_ready=1, tables cleared. A following query returns 0.
- Same-edge cfg write (enable a matching cube0) and in_valid in IDLE -> the query returns out_y=1.

Source files
------------

// File: rtl/autosym_pkg.sv
// Shared sizing, cfg encodings and FSM state codes for the autosymmetric expander.
// Optional macro AUTOSYM_EARLY_EXIT_EN is consumed by autosym_expander.
package autosym_pkg;

  localparam int unsigned N_IN    = 6;
  localparam int unsigned N_RED   = 4;
  localparam int unsigned N_CUBES = 8;

  localparam int unsigned CW = (N_IN > 2 * N_RED + 1) ? N_IN : 2 * N_RED + 1;

  localparam int unsigned ENABLE_BIT = 2 * N_RED;
  localparam int unsigned CARE_LSB   = N_RED;
  localparam int unsigned VALUE_LSB  = 0;

  localparam int unsigned IDX_W  = $clog2(N_CUBES);
  localparam int unsigned ROW_W  = $clog2(N_RED);
  localparam int unsigned ADDR_W = $clog2((N_RED > N_CUBES) ? N_RED : N_CUBES);

  localparam logic CfgRow  = 1'b0;
  localparam logic CfgCube = 1'b1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StProj = 2'd1;
  localparam logic [1:0] StScan = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  typedef struct packed {
    logic             en;
    logic [N_RED-1:0] care;
    logic [N_RED-1:0] value;
  } cube_t;

endpackage

// File: rtl/autosym_project.sv
// GF(2) matrix-vector product: z[j] = parity(rows[j] & x).
module autosym_project
  import autosym_pkg::*;
(
  input  logic [N_RED-1:0][N_IN-1:0] rows,
  input  logic [N_IN-1:0]            x,
  output logic [N_RED-1:0]           z
);

  always_comb begin
    z = '0;
    for (int j = 0; j < N_RED; j++) begin
      z[j] = ^(rows[j] & x);
    end
  end

endmodule

// File: rtl/autosym_expander.sv
// Evaluates f(x) = f_k(A*x) from a programmable projection matrix and cube cover.
// Define AUTOSYM_EARLY_EXIT_EN to stop the cube scan at the first match.
module autosym_expander
  import autosym_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic              cfg_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y
);

  logic [1:0]                  state_q, state_d;
  logic [N_RED-1:0][N_IN-1:0]  rows_q;
  cube_t [N_CUBES-1:0]         cubes_q;
  logic [N_IN-1:0]             x_q;
  logic [N_RED-1:0]            z_q, z_d;
  logic [IDX_W-1:0]            idx_q;
  logic                        y_q;
  cube_t                       cube_cur;
  logic                        match, last;

  autosym_project u_project (
    .rows (rows_q),
    .x    (x_q),
    .z    (z_d)
  );

  assign cube_cur = cubes_q[idx_q];
  assign match    = cube_cur.en & (((z_q ^ cube_cur.value) & cube_cur.care) == '0);
  assign last     = (idx_q == IDX_W'(N_CUBES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = StProj;
      StProj: state_d = StScan;
`ifdef AUTOSYM_EARLY_EXIT_EN
      StScan: if (match || last) state_d = StDone;
`else
      StScan: if (last) state_d = StDone;
`endif
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rows_q  <= '0;
      cubes_q <= '0;
      x_q     <= '0;
      z_q     <= '0;
      idx_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Table writes only land while idle; in-flight queries see frozen contents.
      if (cfg_we && state_q == StIdle) begin
        if (cfg_sel == CfgRow && 32'(cfg_addr) < N_RED) begin
          rows_q[cfg_addr[ROW_W-1:0]] <= cfg_data[N_IN-1:0];
        end else if (cfg_sel == CfgCube && 32'(cfg_addr) < N_CUBES) begin
          cubes_q[cfg_addr[IDX_W-1:0]] <= '{en:    cfg_data[ENABLE_BIT],
                                            care:  cfg_data[CARE_LSB +: N_RED],
                                            value: cfg_data[VALUE_LSB +: N_RED]};
        end
      end
      case (state_q)
        StIdle: if (in_valid) x_q <= in_x;
        StProj: begin
          z_q   <= z_d;
          idx_q <= '0;
          y_q   <= 1'b0;
        end
        StScan: begin
          y_q <= y_q | match;
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign cfg_busy  = (state_q != StIdle);
  assign out_y     = y_q;

endmodule
